// File: rtl/axi_pkg.sv
// Shared AXI definitions for the master write initiator and the slave write-channel handlers.
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_e;

endpackage

// File: rtl/axi_w_holdreg.sv
// Single-entry W-channel holding register: the payload only changes when the slot is
// empty or draining, so WDATA/WSTRB/WLAST stay stable while WVALID && !WREADY.
module axi_w_holdreg
    import axi_pkg::*;
#(
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] strb_i,
    input  logic                last_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W/8-1:0] strb_o,
    output logic                last_o
);

    logic                full_q, full_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;
    logic                last_q, last_d;

    // The caller only asserts load_i when the slot is empty or being drained this cycle.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        strb_d = strb_q;
        last_d = last_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            strb_d = strb_i;
            last_d = last_i;
        end else if (full_q && ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            full_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            strb_q <= strb_d;
            last_q <= last_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axi_master_write.sv
// AXI4 write initiator: one request -> AW, len+1 W beats, then B. One transaction in flight.
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ADDR  | AWVALID held until AWREADY
// DATA  | requester beats pass through the W holding register
// RESP  | BREADY high, waiting for the write response
module axi_master_write
    import axi_pkg::*;
#(
    parameter logic [3:0] MASTER_ID = 4'd0,
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         LEN_W     = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [2:0]          req_size,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                busy,
    output logic                done,
    output logic                resp_err,
    output logic [3:0]          AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [LEN_W-1:0]    AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [LEN_W:0]    load_cnt_q, load_cnt_d;
    logic              resp_err_q, resp_err_d;
    logic              done_q, done_d;

    logic w_full;
    logic w_last;
    logic wd_fire;
    logic w_fire;
    logic load_last;

    // load_cnt is one bit wider than len so a 16-beat burst can count past the last beat.
    assign wd_ready  = (state_q == DATA) && (load_cnt_q <= {1'b0, len_q}) && (!w_full || WREADY);
    assign wd_fire   = wd_valid && wd_ready;
    assign w_fire    = w_full && WREADY;
    assign load_last = (load_cnt_q == {1'b0, len_q});

    axi_w_holdreg #(
        .DATA_W (DATA_W)
    ) u_w_holdreg (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .load_i  (wd_fire),
        .data_i  (wd_data),
        .strb_i  (wd_strb),
        .last_i  (load_last),
        .ready_i (WREADY),
        .valid_o (w_full),
        .data_o  (WDATA),
        .strb_o  (WSTRB),
        .last_o  (w_last)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        load_cnt_d = load_cnt_q;
        resp_err_d = resp_err_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    len_d      = req_len;
                    size_d     = req_size;
                    load_cnt_d = '0;
                    resp_err_d = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (AWREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wd_fire) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
                if (w_fire && w_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (BVALID) begin
                    resp_err_d = (BRESP != RESP_OKAY) || (BID != MASTER_ID);
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            load_cnt_q <= '0;
            resp_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            load_cnt_q <= load_cnt_d;
            resp_err_q <= resp_err_d;
            done_q     <= done_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign resp_err  = resp_err_q;
    assign AWID      = MASTER_ID;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWBURST   = BURST_INCR;
    assign AWVALID   = (state_q == ADDR);
    assign WVALID    = w_full;
    assign WLAST     = w_last;
    assign BREADY    = (state_q == RESP);

endmodule

// File: tb/tb_axi_master_write.sv
// Directed bench for axi_master_write: drives on the falling edge, samples 1 ns later.
module tb_axi_master_write;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [2:0]  req_size;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        busy;
    logic        done;
    logic        resp_err;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_master_write dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .busy      (busy),
        .done      (done),
        .resp_err  (resp_err),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat i of a burst carries base+i with strobes F^i.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] base,
                           input int aw_stall, input bit toggle, input logic [1:0] bresp,
                           input logic [3:0] bid, input bit exp_err, input int abort_after,
                           input bit pre, input bit nxt, input logic [31:0] nxt_addr,
                           input logic [3:0] nxt_len);
        int          beat_in;
        int          beat_out;
        int          cyc;
        bit          fin;
        logic        pv;
        logic        pr;
        logic        pl;
        logic [31:0] pd;
        if (!pre) begin
            @(negedge ACLK);
            req_valid = 1'b1;
            req_addr  = addr;
            req_len   = len;
            req_size  = 3'd2;
            #1;
            chk("req_ready", 64'(req_ready), 64'(1));
            @(negedge ACLK);
            req_valid = 1'b0;
            #1;
        end
        chk("aw_valid", 64'(AWVALID), 64'(1));
        chk("aw_addr", 64'(AWADDR), 64'(addr));
        chk("aw_len", 64'(AWLEN), 64'(len));
        chk("aw_size", 64'(AWSIZE), 64'(2));
        chk("aw_burst", 64'(AWBURST), 64'(1));
        chk("aw_id", 64'(AWID), 64'(0));
        chk("err_clr_on_accept", 64'(resp_err), 64'(0));
        chk("busy", 64'(busy), 64'(1));
        for (int i = 0; i < aw_stall; i++) begin
            AWREADY  = 1'b0;
            wd_valid = 1'b1;
            #1;
            chk("aw_stall_valid", 64'(AWVALID), 64'(1));
            chk("aw_stall_addr", 64'(AWADDR), 64'(addr));
            chk("aw_stall_wd_ready", 64'(wd_ready), 64'(0));
            @(negedge ACLK);
        end
        AWREADY  = 1'b1;
        wd_valid = 1'b1;
        #1;
        chk("aw_hs_valid", 64'(AWVALID), 64'(1));
        chk("aw_hs_wd_ready", 64'(wd_ready), 64'(0));
        @(negedge ACLK);
        AWREADY  = 1'b0;
        beat_in  = 0;
        beat_out = 0;
        cyc      = 0;
        fin      = 1'b0;
        pv       = 1'b0;
        pr       = 1'b0;
        pl       = 1'b0;
        pd       = '0;
        while (!fin && cyc < 100) begin
            if (abort_after >= 0 && beat_out == abort_after) begin
                ARESETn  = 1'b0;
                wd_valid = 1'b0;
                WREADY   = 1'b0;
                @(negedge ACLK);
                #1;
                chk("rst_awvalid", 64'(AWVALID), 64'(0));
                chk("rst_wvalid", 64'(WVALID), 64'(0));
                chk("rst_wlast", 64'(WLAST), 64'(0));
                chk("rst_bready", 64'(BREADY), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_req_ready", 64'(req_ready), 64'(1));
                chk("rst_done", 64'(done), 64'(0));
                ARESETn = 1'b1;
                return;
            end
            wd_valid = 1'b1;
            wd_data  = base + 32'(beat_in);
            wd_strb  = 4'hF ^ 4'(beat_in);
            WREADY   = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (pv && !pr) begin
                chk("w_stable_valid", 64'(WVALID), 64'(1));
                chk("w_stable_data", 64'(WDATA), 64'(pd));
                chk("w_stable_last", 64'(WLAST), 64'(pl));
            end
            if (wd_ready) begin
                chk("wd_no_extra_beat", 64'(beat_in <= int'(len)), 64'(1));
                beat_in++;
            end
            if (WVALID && WREADY) begin
                chk("w_data", 64'(WDATA), 64'(base + 32'(beat_out)));
                chk("w_strb", 64'(WSTRB), 64'(4'hF ^ 4'(beat_out)));
                chk("w_last", 64'(WLAST), 64'(beat_out == int'(len)));
                if (WLAST) fin = 1'b1;
                beat_out++;
            end
            pv = WVALID;
            pr = WREADY;
            pd = WDATA;
            pl = WLAST;
            cyc++;
            @(negedge ACLK);
        end
        chk("w_finished", 64'(fin), 64'(1));
        chk("w_beat_count", 64'(beat_out), 64'(int'(len) + 1));
        wd_valid = 1'b1;
        WREADY   = 1'b0;
        BVALID   = 1'b1;
        BRESP    = bresp;
        BID      = bid;
        #1;
        chk("b_ready", 64'(BREADY), 64'(1));
        chk("b_wd_ready", 64'(wd_ready), 64'(0));
        chk("b_wvalid", 64'(WVALID), 64'(0));
        @(negedge ACLK);
        BVALID   = 1'b0;
        wd_valid = 1'b0;
        if (nxt) begin
            req_valid = 1'b1;
            req_addr  = nxt_addr;
            req_len   = nxt_len;
        end
        #1;
        chk("done", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_req_ready", 64'(req_ready), 64'(1));
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        @(negedge ACLK);
        req_valid = 1'b0;
        #1;
        chk("done_pulse", 64'(done), 64'(0));
        if (nxt) begin
            chk("b2b_awvalid", 64'(AWVALID), 64'(1));
            chk("b2b_awaddr", 64'(AWADDR), 64'(nxt_addr));
        end else begin
            chk("resp_err_hold", 64'(resp_err), 64'(exp_err));
        end
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        wd_strb   = '0;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BID       = '0;
        BRESP     = '0;
        BVALID    = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_awvalid", 64'(AWVALID), 64'(0));
        chk("rst_wvalid", 64'(WVALID), 64'(0));
        chk("rst_wlast", 64'(WLAST), 64'(0));
        chk("rst_bready", 64'(BREADY), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_awaddr", 64'(AWADDR), 64'(0));
        chk("rst_awlen", 64'(AWLEN), 64'(0));
        chk("rst_awsize", 64'(AWSIZE), 64'(0));
        chk("rst_wdata", 64'(WDATA), 64'(0));
        chk("rst_wstrb", 64'(WSTRB), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        ARESETn = 1'b1;

        // single beat
        run_txn(32'h0000_1000, 4'd0, 32'hDEAD_BEEF, 0, 1'b0, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // 4-beat burst, WREADY toggling
        run_txn(32'h0000_2000, 4'd3, 32'h0000_0001, 0, 1'b1, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // AW stall for 5 cycles
        run_txn(32'h0000_3000, 4'd1, 32'h0000_0100, 5, 1'b0, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // SLVERR, then a clean transaction clears the flag
        run_txn(32'h0000_4000, 4'd0, 32'h0000_0055, 0, 1'b0, 2'b10, 4'd0, 1'b1, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        run_txn(32'h0000_4100, 4'd1, 32'h0000_0066, 0, 1'b0, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // BID mismatch
        run_txn(32'h0000_4200, 4'd0, 32'h0000_0077, 0, 1'b0, 2'b00, 4'h3, 1'b1, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // reset after beat 2 of a 4-beat burst, then a fresh burst
        run_txn(32'h0000_5000, 4'd3, 32'h0000_0010, 0, 1'b0, 2'b00, 4'd0, 1'b0, 2, 1'b0, 1'b0, 32'h0, 4'd0);
        run_txn(32'h0000_6000, 4'd3, 32'h0000_0020, 0, 1'b1, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 4'd0);
        // back-to-back: second request accepted in the done cycle
        run_txn(32'h0000_7000, 4'd1, 32'h0000_0030, 0, 1'b0, 2'b00, 4'd0, 1'b0, -1, 1'b0, 1'b1, 32'h0000_7100, 4'd2);
        run_txn(32'h0000_7100, 4'd2, 32'h0000_0040, 0, 1'b0, 2'b00, 4'd0, 1'b0, -1, 1'b1, 1'b0, 32'h0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_master_write.md
Name: axi_master_write

Overview:
- AXI4 write-initiator (master side) for a CPU/DMA requester.
- Accepts one write request (address, burst length, size) plus a stream of data beats from the requester. Issues AW, then W beats, then collects B.
- Is the master-side counterpart of the slave write-channel handlers on the bus.
- Sits between a core's store path and the AXI interconnect master port.

Parameters:
- MASTER_ID, 4'd0, constant driven on AWID and expected on BID.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- LEN_W, 4, AWLEN width; maximum burst is 16 beats.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- req_valid  in  1  write request valid
- req_ready  out  1  request accepted; high only in IDLE
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats minus 1
- req_size  in  3  bytes-per-beat encoding
- wd_valid  in  1  requester data beat valid
- wd_ready  out  1  requester data beat accepted
- wd_data  in  DATA_W  beat data
- wd_strb  in  DATA_W/8  beat byte strobes
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the B handshake
- resp_err  out  1  last transaction got BRESP != OKAY or a BID mismatch
- AWID  out  4  = MASTER_ID
- AWADDR  out  ADDR_W
- AWLEN  out  LEN_W
- AWSIZE  out  3
- AWBURST  out  2  fixed 2'b01 (INCR)
- AWVALID  out  1
- AWREADY  in  1
- WDATA  out  DATA_W
- WSTRB  out  DATA_W/8
- WLAST  out  1
- WVALID  out  1
- WREADY  in  1
- BID  in  4
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1

Behaviour:
- Reset values (ARESETn low at a clock edge): state=IDLE; AWVALID, WVALID, WLAST, BREADY, done, resp_err, busy all 0; AWADDR/AWLEN/AWSIZE/WDATA/WSTRB registers 0; counters 0. req_ready=1 once state is IDLE. Reset mid-transaction aborts unconditionally; no B is awaited.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1.
  - req_valid&&req_ready latches addr/len/size into the AW registers, clears resp_err, clears load_cnt, and moves to ADDR.
- ADDR: AWVALID=1, held stable until AWREADY (AXI stability rule). AW handshake -> DATA.
  - Latency: AWVALID rises in the cycle after the request is accepted.
- DATA: one-entry W holding register with flag w_full. WVALID=w_full.
  - wd_ready = (state==DATA) && (load_cnt <= len_q) && (!w_full || WREADY).
  - On a wd handshake: load WDATA/WSTRB; WLAST_q=(load_cnt==len_q); load_cnt++; w_full stays or becomes 1.
  - On a W handshake with no simultaneous load: w_full<=0.
  - A simultaneous load and drain gives full throughput of 1 beat/cycle.
  - WVALID/WDATA/WLAST are held stable while WVALID&&!WREADY.
  - W handshake with WLAST=1 -> RESP; w_full<=0.
  - len=0 means a single beat with WLAST=1.
- RESP: BREADY=1.
  - On BVALID: resp_err<=(BRESP!=2'b00)||(BID!=MASTER_ID); next cycle done=1 and state=IDLE.
- wd_valid is ignored outside DATA. Beats offered beyond len+1 are never accepted (wd_ready=0).
- AWSIZE is passed through; no narrow-transfer address math. AWADDR does not change during the burst.
- resp_err holds until the next request is accepted.
- A new request can be accepted in the same cycle done is high, since the state is already IDLE.
- Never issues outstanding transactions: exactly one AW/W/B sequence in flight.

Decomposition:
- Shared package axi_pkg holds:
  - state enum {IDLE, ADDR, DATA, RESP}
  - BURST_INCR=2'b01, RESP_OKAY=2'b00
  - AXI width constants, shared with the slave handlers.
- One natural sub-module: axi_w_holdreg, the single-entry W holding register with valid/ready, WLAST tag and stability guarantee.

Test Plan:
- Single beat:
  - Stimulus: req addr=0x0000_1000, len=0, size=2; AWREADY=1; wd 0xDEADBEEF strb 4'hF; WREADY=1; BVALID next cycle with BRESP=00, BID=MASTER_ID.
  - Response: AWADDR=0x1000, AWLEN=0; one W beat with WLAST=1; done pulses once; resp_err=0.
- 4-beat burst with backpressure:
  - Stimulus: len=3, data 1..4; WREADY toggles 1,0,1,0...
  - Response: 4 beats in order; WDATA/WVALID stable during stalls; WLAST only on beat 4; wd_ready never admits a 5th beat.
- AW stall:
  - Stimulus: AWREADY held low for 5 cycles.
  - Response: AWVALID high and AWADDR constant for 5 cycles; wd_ready=0 until the AW handshake.
- Error response:
  - Stimulus: BRESP=2'b10 → resp_err=1 after done.
  - Stimulus: next request with BRESP=00 → resp_err clears on accept and stays 0.
- Reset mid-burst:
  - Stimulus: ARESETn low after beat 2 of a len=3 burst.
  - Response: next edge gives state IDLE, all valids 0, req_ready=1; a fresh request then completes normally.
- Back-to-back:
  - Stimulus: req_valid held high continuously.
  - Response: the second request is accepted in the cycle done=1; AWVALID rises the following cycle.
